// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer for the 24-bit CPU: PC, fetch handshake, decode,
// ALU dispatch, conditional branches and a small hardware return stack.
module cpu_seq_ctrl #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 24,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [3:0]        ccr_in,
  output logic              busy,
  output logic              err
);

  localparam int OPC_W = DATA_W - ADDR_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_BRANCH = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(32'h800);
  localparam logic [OPC_W-1:0] OP_JZE = OPC_W'(32'h801);
  localparam logic [OPC_W-1:0] OP_JNE = OPC_W'(32'h802);
  localparam logic [OPC_W-1:0] OP_JCY = OPC_W'(32'h803);
  localparam logic [OPC_W-1:0] OP_RET = OPC_W'(32'h804);
  localparam logic [OPC_W-1:0] OP_BSR = OPC_W'(32'h805);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);
  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);

  logic [2:0]        state;
  logic              flag_n;
  logic              flag_z;
  logic              flag_cy;
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_rel;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [2:0]        boundary;
  logic              unused_ccr;

  assign opcode     = ir[DATA_W-1:ADDR_W];
  assign operand    = ir[ADDR_W-1:0];
  assign pc_inc     = pc + ADDR_ONE;
  assign pc_rel     = pc + operand;
  assign push_idx   = IDX_W'(sp);
  assign pop_idx    = IDX_W'(sp - SP_ONE);
  assign boundary   = run ? S_FETCH : S_IDLE;
  assign unused_ccr = ccr_in[1];

  assign mem_req  = (state == S_FETCH);
  assign mem_addr = pc;
  assign busy     = (state != S_IDLE);
  assign err      = (state == S_ERROR);

  // run is only consulted at the instruction boundary, so a running op always completes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_cy   <= 1'b0;
      sp        <= '0;
      alu_start <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!opcode[OPC_W-1]) begin
            state     <= S_EXEC;
            alu_start <= 1'b1;
          end else begin
            state <= S_BRANCH;
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            flag_n  <= ccr_in[3];
            flag_z  <= ccr_in[2];
            flag_cy <= ccr_in[0];
            pc      <= pc_inc;
            state   <= boundary;
          end
        end
        // Branch conditions read the flags latched at the last alu_done
        S_BRANCH: begin
          state <= boundary;
          case (opcode)
            OP_JMP: pc <= operand;
            OP_JZE: pc <= flag_z  ? operand : pc_inc;
            OP_JNE: pc <= flag_n  ? operand : pc_inc;
            OP_JCY: pc <= flag_cy ? operand : pc_inc;
            OP_RET: begin
              if (sp == '0) begin
                state <= S_ERROR;
              end else begin
                pc <= stack[pop_idx];
                sp <= sp - SP_ONE;
              end
            end
            OP_BSR: begin
              if (sp == SP_FULL) begin
                state <= S_ERROR;
              end else begin
                stack[push_idx] <= pc_inc;
                sp              <= sp + SP_ONE;
                pc              <= pc_rel;
              end
            end
            default: pc <= pc_inc;
          endcase
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
